// File: rtl/longop_pkg.sv
// longop_pkg: shared types and constants for the long-latency op sequencer.
//   state_t : sequencer FSM states
//   unit_t  : which long-latency unit owns the in-flight operation
//   LONGOP_WIDTH : default operand/result width
package longop_pkg;

    localparam int LONGOP_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DONE  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    typedef enum logic {
        UNIT_MUL = 1'b0,
        UNIT_DIV = 1'b1
    } unit_t;

endpackage

// File: rtl/longop_sequencer.sv
// longop_sequencer: issues multiply/divide to the shared multiplier and
// divider, stalls the front of the pipe while a unit is busy, and registers
// the unit result for the EX result mux. A branch-recovery kill abandons the
// in-flight op; the unit's late result is then drained and dropped.
//
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   op_mul, op_div               EX-stage instruction is a multiply / divide
//   kill                         discard in-flight op (IDLE/WAIT only)
//   opA, opB                     operands (latched by the units at issue)
//   stall                        freeze PC and front pipeline walls
//   mul_valid_in, div_valid_in   one-cycle issue pulses
//   mul_valid_out, mul_out       multiplier result strobe/data
//   div_valid_out, div_quotient  divider result strobe/data
//   result, result_valid         registered result, valid for one cycle
//
// Build option: LONGOP_DIVZERO_BYPASS_EN -- a divide by zero skips the
// divider and returns all-ones directly.
module longop_sequencer
    import longop_pkg::*;
#(
    parameter int WIDTH = LONGOP_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             op_mul,
    input  logic             op_div,
    input  logic             kill,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic             stall,
    output logic             mul_valid_in,
    input  logic             mul_valid_out,
    input  logic [WIDTH-1:0] mul_out,
    output logic             div_valid_in,
    input  logic             div_valid_out,
    input  logic [WIDTH-1:0] div_quotient,
    output logic [WIDTH-1:0] result,
    output logic             result_valid
);

    state_t           r_state, w_state_next;
    unit_t            r_unit, w_unit_next;
    logic [WIDTH-1:0] r_result, w_result_next;

    logic             w_sel_valid;
    logic [WIDTH-1:0] w_sel_data;
    logic             w_stall, w_mvi, w_dvi;
    logic             w_unused_ops;

    // Operands are consumed by the units themselves; only opB is inspected
    // here, and only when the div-by-zero bypass is built in.
    assign w_unused_ops = ^{opA, opB};

    // Only the unit that owns the op may complete it; the other is ignored.
    assign w_sel_valid = (r_unit == UNIT_MUL) ? mul_valid_out : div_valid_out;
    assign w_sel_data  = (r_unit == UNIT_MUL) ? mul_out       : div_quotient;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_unit   <= UNIT_MUL;
            r_result <= '0;
        end else begin
            r_state  <= w_state_next;
            r_unit   <= w_unit_next;
            r_result <= w_result_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_unit_next   = r_unit;
        w_result_next = r_result;
        w_stall       = 1'b0;
        w_mvi         = 1'b0;
        w_dvi         = 1'b0;
        case (r_state)
            IDLE: begin
                if ((op_mul || op_div) && !kill) begin
                    w_stall = 1'b1;
                    if (op_mul) begin
                        // multiply wins when both decode bits are set
                        w_unit_next  = UNIT_MUL;
                        w_mvi        = 1'b1;
                        w_state_next = WAIT;
                    end else begin
                        w_unit_next = UNIT_DIV;
`ifdef LONGOP_DIVZERO_BYPASS_EN
                        if (opB == '0) begin
                            w_result_next = '1;
                            w_state_next  = DONE;
                        end else begin
                            w_dvi        = 1'b1;
                            w_state_next = WAIT;
                        end
`else
                        w_dvi        = 1'b1;
                        w_state_next = WAIT;
`endif
                    end
                end
            end
            WAIT: begin
                if (kill) begin
                    // a result landing with the kill is simply dropped
                    w_state_next = w_sel_valid ? IDLE : DRAIN;
                end else begin
                    w_stall = 1'b1;
                    if (w_sel_valid) begin
                        w_result_next = w_sel_data;
                        w_state_next  = DONE;
                    end
                end
            end
            DONE: begin
                // EX advances on this edge; op_* still shows the same
                // instruction, so it must not be re-issued here.
                w_state_next = IDLE;
            end
            DRAIN: begin
                // a new long op must wait until the killed one is flushed
                w_stall = op_mul || op_div;
                if (w_sel_valid) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Combinational outputs are forced low while reset is asserted so the
    // front end is released immediately, not just at the next edge.
    assign stall        = w_stall & reset_n;
    assign mul_valid_in = w_mvi & reset_n;
    assign div_valid_in = w_dvi & reset_n;
    assign result       = r_result;
    assign result_valid = (r_state == DONE);

endmodule
